// File: rtl/vga_reg_pkg.sv
// Shared types and constants for the VGA register-write path.
//   ADDR_W/DATA_W : Avalon address and writedata widths
//   REG_BG_*      : background colour register addresses
//   reg_cmd_t     : one queued register write {addr, data}
//   wr_state_t    : write sequencer states
package vga_reg_pkg;

   localparam int unsigned ADDR_W = 3;
   localparam int unsigned DATA_W = 8;

   localparam logic [ADDR_W-1:0] REG_BG_R = 3'h0;
   localparam logic [ADDR_W-1:0] REG_BG_G = 3'h1;
   localparam logic [ADDR_W-1:0] REG_BG_B = 3'h2;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } reg_cmd_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      WRITE = 2'd2
   } wr_state_t;

endpackage

// File: rtl/vga_reg_writer_if.sv
// Command input and Avalon-MM write output bundle of vga_reg_writer.
//   cmd_valid/cmd_ready/cmd_addr/cmd_data : command push handshake
//   av_chipselect/av_write/av_address/av_writedata : register-write beat
// modport master : the writer (accepts commands, issues Avalon writes)
// modport slave  : the surroundings (command source and display peripheral)
interface vga_reg_writer_if;
   import vga_reg_pkg::*;

   logic              cmd_valid;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_data;
   logic              av_chipselect;
   logic              av_write;
   logic [ADDR_W-1:0] av_address;
   logic [DATA_W-1:0] av_writedata;

   modport master (
      input  cmd_valid, cmd_addr, cmd_data,
      output cmd_ready,
      output av_chipselect, av_write, av_address, av_writedata
   );

   modport slave (
      output cmd_valid, cmd_addr, cmd_data,
      input  cmd_ready,
      input  av_chipselect, av_write, av_address, av_writedata
   );
endinterface

// File: rtl/reg_cmd_fifo.sv
// Synchronous FIFO of register-write commands.
//   clk, reset_n : clock, async active-low reset
//   push/push_data : enqueue (ignored when full or flushing)
//   pop            : dequeue head (ignored when empty or flushing)
//   flush          : discard everything at the next edge
//   rd_data        : registered popped entry, zero in cycles after no pop
//   count          : entries queued
module reg_cmd_fifo
   import vga_reg_pkg::*;
#(
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  reg_cmd_t                 push_data,
   input  logic                     pop,
   input  logic                     flush,
   output reg_cmd_t                 rd_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   reg_cmd_t        mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic            push_ok;
   logic            pop_ok;

   assign push_ok = push & (count < CW'(DEPTH)) & ~flush;
   assign pop_ok  = pop & (count != '0) & ~flush;

   // Storage array, no reset needed
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

   // Pointers wrap naturally at DEPTH (power of two); count disambiguates full/empty
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         rd_data <= '0;
      end else if (flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         rd_data <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
         rd_data <= pop_ok ? mem[rd_ptr] : '0;
         count   <= count + CW'(push_ok) - CW'(pop_ok);
      end
   end

endmodule

// File: rtl/vga_reg_writer.sv
// Replays queued (address, data) commands as single-cycle Avalon-MM write
// beats, optionally only inside a window opened by the VGA_VS falling edge.
//   clk, reset_n : clock, async active-low reset
//   bus          : command handshake in, Avalon write beat out
//   flush        : drop all queued commands
//   gate_en      : 1 = write only while the vsync window is open
//   vga_vs       : active-low vertical sync
//   fifo_count   : commands queued
//   win_open     : vsync write window active
module vga_reg_writer
   import vga_reg_pkg::*;
#(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned WINDOW = 2048
) (
   input  logic                   clk,
   input  logic                   reset_n,
   vga_reg_writer_if.master       bus,
   input  logic                   flush,
   input  logic                   gate_en,
   input  logic                   vga_vs,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic                   win_open
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam int unsigned WW = $clog2(WINDOW + 1);

   wr_state_t        state;
   logic             cs;
   logic             vs_prev;
   logic             vs_fall;
   logic [WW-1:0]    win_cnt;
   logic             may_issue;
   logic             push;
   logic             pop;
   reg_cmd_t         push_data;
   reg_cmd_t         rd_data;

   assign bus.cmd_ready = fifo_count < CW'(DEPTH);
   assign push          = bus.cmd_valid & bus.cmd_ready;
   assign push_data     = '{addr: bus.cmd_addr, data: bus.cmd_data};
   // A pop is committed by being in WRITE; flush cancels it
   assign pop           = (state == WRITE) & ~flush;

   assign vs_fall   = vs_prev & ~vga_vs;
   assign win_open  = (win_cnt != '0);
   assign may_issue = ~gate_en | win_open;

   reg_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .flush     (flush),
      .rd_data   (rd_data),
      .count     (fifo_count)
   );

   // Write window: reload on every vsync falling edge, count down to zero
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vs_prev <= 1'b1;
         win_cnt <= '0;
      end else begin
         vs_prev <= vga_vs;
         if (vs_fall)              win_cnt <= WW'(WINDOW);
         else if (win_cnt != '0)   win_cnt <= win_cnt - WW'(1);
      end
   end

   // Sequencer; the beat strobe follows the pop by one edge, aligned with rd_data
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         cs    <= 1'b0;
      end else begin
         cs <= pop;
         if (flush) begin
            state <= IDLE;
         end else begin
            unique case (state)
               IDLE: begin
                  if (fifo_count != '0) state <= may_issue ? WRITE : WAIT;
               end
               WAIT: begin
                  if (may_issue) state <= WRITE;
               end
               WRITE: begin
                  // Entries left after this pop decide whether to continue
                  if (fifo_count > CW'(1)) state <= may_issue ? WRITE : WAIT;
                  else                     state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.av_chipselect = cs;
   assign bus.av_write      = cs;
   assign bus.av_address    = rd_data.addr;
   assign bus.av_writedata  = rd_data.data;

endmodule
